msg_streamer: RTL

- Sequential reader placed directly downstream of the 1024x8 message RAM.
- On a start request it walks the RAM from a base address and stops at a NUL byte (0x00) or after MAX_LEN bytes.
- Each fetched byte goes to the UART transmitter over a valid/ready handshake.
- An optional repeat timer re-sends the message periodically; the board demo uses this to print the preloaded greeting once per second.

---
 rtl/msg_streamer_pkg.sv | 12 +
 rtl/msg_repeat_timer.sv | 29 ++
 rtl/msg_streamer.sv | 110 +++++++++++
 3 files changed

// File: rtl/msg_streamer_pkg.sv
// Shared widths, types and FSM encoding for the message streamer.
package msg_streamer_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

endpackage

// File: rtl/msg_repeat_timer.sv
// Counts enabled (idle) cycles; O_EXPIRE is high on the last of REPEAT_CYCLES of them.
module msg_repeat_timer #(
    parameter int REPEAT_CYCLES = 100_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic I_EN,
    output logic O_EXPIRE
);

    localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] r_cnt;

    // A zero period folds the expire term to constant low, so the counter is dead logic.
    assign O_EXPIRE = (REPEAT_CYCLES != 0) && I_EN && (r_cnt == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (!I_EN || O_EXPIRE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/msg_streamer.sv
// Walks the message RAM from a base address until NUL or MAX_LEN bytes,
// handing each byte to the UART TX over valid/ready; optional periodic restart.
module msg_streamer
    import msg_streamer_pkg::*;
#(
    parameter int MAX_LEN       = 1024,
    parameter int REPEAT_CYCLES = 100_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_START,
    input  logic [ADDR_W-1:0] I_BASE,
    output logic [ADDR_W-1:0] O_RADDR,
    input  logic [DATA_W-1:0] I_RDATA,
    output logic              O_TX_VALID,
    output logic [DATA_W-1:0] O_TX_DATA,
    input  logic              I_TX_READY,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic [ADDR_W:0]   O_COUNT
);

    localparam int CNT_W = ADDR_W + 1;

    state_t           r_state;
    state_t           w_next;
    addr_t            r_raddr;
    byte_t            r_tx_data;
    logic             r_tx_valid;
    logic [CNT_W-1:0] r_count;

    logic             w_timer_expire;
    logic             w_start;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_last;

    msg_repeat_timer #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .I_EN     (r_state == S_IDLE),
        .O_EXPIRE (w_timer_expire)
    );

    // Manual and timed starts merge into one, so a coincidence cannot double-trigger.
    assign w_start     = I_START || w_timer_expire;
    assign w_count_inc = r_count + 1'b1;
    assign w_last      = (w_count_inc == CNT_W'(MAX_LEN));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_FETCH;
            S_FETCH: w_next = (I_RDATA == '0) ? S_DONE : S_SEND;
            S_SEND:  if (I_TX_READY) w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_raddr    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_raddr <= I_BASE;
                        r_count <= '0;
                    end
                end
                S_FETCH: begin
                    if (I_RDATA != '0) begin
                        r_tx_data  <= I_RDATA;
                        r_tx_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (I_TX_READY) begin
                        r_tx_valid <= 1'b0;
                        r_count    <= w_count_inc;
                        r_raddr    <= r_raddr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign O_RADDR    = r_raddr;
    assign O_TX_VALID = r_tx_valid;
    assign O_TX_DATA  = r_tx_data;
    assign O_COUNT    = r_count;
    assign O_BUSY     = (r_state != S_IDLE);
    assign O_DONE     = (r_state == S_DONE);

endmodule
